miriscv_lsu_gnt: RTL and testbench
==================================

MIRISCV_LSU_GNT -- requirements
Module: miriscv_lsu_gnt

Interface
REQ-001 Parameter XLEN, default 32, data/address width; legal values 32 and 64.
REQ-002 Parameter MEM_ACCESS_W, default 3, width of lsu_size_i: [1:0] 0=byte, 1=half, 2=word, 3=double; [2]=1 means unsigned load.
REQ-003 clk_i  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 data_req_o  output  1  memory request.
REQ-006 data_gnt_i  input  1  memory accepts request in the current cycle.
REQ-007 data_rvalid_i  input  1  load response valid.
REQ-008 data_rdata_i  input  XLEN  load response data.
REQ-009 data_we_o  output  1  write enable.
REQ-010 data_be_o  output  XLEN/8  byte enables.
REQ-011 data_addr_o  output  XLEN  byte address, passed through unmodified.
REQ-012 data_wdata_o  output  XLEN  store data.
REQ-013 lsu_req_i, lsu_kill_i, lsu_we_i  input  1 each  pipeline request, squash, store select.
REQ-014 lsu_size_i  input  MEM_ACCESS_W  access size and signedness.
REQ-015 lsu_addr_i, lsu_data_i  input  XLEN each  address, store data.
REQ-016 lsu_data_o  output  XLEN  formatted load result.
REQ-017 lsu_stall_o  output  1  pipeline must hold the current request.
REQ-018 lsu_misalign_o  output  1  misaligned or illegal access; the pipeline raises the exception.

Function
REQ-019 FSM states: S_IDLE, S_WAIT_RVALID, S_DRAIN.
REQ-020 Misaligned: half with addr[0]!=0; word with addr[1:0]!=0; double with addr[2:0]!=0; size=3 with XLEN=32 is illegal and also reported as misaligned.
REQ-021 lsu_misalign_o = lsu_req_i & ~lsu_kill_i & misaligned, combinational; a misaligned request issues no data_req_o and no stall.
REQ-022 data_req_o = lsu_req_i & ~lsu_kill_i & ~misaligned & (state==S_IDLE).
REQ-023 S_IDLE with data_req_o=1 and no gnt: stall=1; remain in S_IDLE; request re-presented next cycle.
REQ-024 S_IDLE, store granted: stall=0 in that cycle; remain in S_IDLE; 0-cycle stall.
REQ-025 S_IDLE, load granted: stall=1; latch addr[$clog2(XLEN/8)-1:0] and lsu_size_i; go to S_WAIT_RVALID.
REQ-026 S_WAIT_RVALID: data_req_o=0; stall=1 until data_rvalid_i.
REQ-027 In the data_rvalid_i cycle: stall=0; lsu_data_o valid; go to S_IDLE. Minimum load latency is 1 stall cycle after grant.
REQ-028 lsu_kill_i in S_IDLE: no request issued, stall=0, no state change.
REQ-029 lsu_kill_i in S_WAIT_RVALID: stall=0 in that cycle; go to S_DRAIN, or S_IDLE if data_rvalid_i arrives in the same cycle.
REQ-030 S_DRAIN: discard the response; data_req_o=0; stall = lsu_req_i & ~lsu_kill_i; data_rvalid_i returns to S_IDLE, with stall=0 and no request issued in that cycle.
REQ-031 data_rvalid_i in S_IDLE is ignored.
REQ-032 data_be_o = size mask (1, 3, 0xF, 0xFF bytes) shifted left by the address byte offset; zero when data_req_o=0.
REQ-033 data_wdata_o = lsu_data_i low byte, half, word or double replicated across XLEN.
REQ-034 Load lane select uses the latched offset and size, not live inputs.
REQ-035 Load result: extract the lane, then sign-extend when size[2]=0, zero-extend when size[2]=1; double ignores size[2].
REQ-036 lsu_data_o is combinational from data_rdata_i; undefined (don't-care) outside the rvalid cycle.

Reset
REQ-037 rst_n=0 at a clock edge forces S_IDLE and clears the latched offset and size.
REQ-038 During reset, the combinational outputs are driven by current inputs with state=S_IDLE.
REQ-039 An outstanding response arriving after reset is ignored per REQ-031.

Verification
REQ-040 XLEN=32, lw 0x100, gnt in cycle 0, rvalid in cycle 3, rdata=0xDEADBEEF -> stall 1 in cycles 0-2, 0 in cycle 3; lsu_data_o=0xDEADBEEF.
REQ-041 lb 0x103, rdata=0x80xxxxxx -> be=0x8, lsu_data_o=0xFFFFFF80; lbu -> 0x00000080.
REQ-042 sh 0x102, data 0x1234, gnt delayed 2 cycles -> req held for 3 cycles, be=0xC, wdata=0x12341234, stall 1,1,0.
REQ-043 lw 0x101 -> misalign=1, req=0, stall=0; XLEN=32 with size=3 -> misalign=1.
REQ-044 Load granted, kill next cycle, rvalid 2 cycles later; meanwhile a new lw is presented -> new req stays 0 and stall=1 until drain completes; new req issued the cycle after.
REQ-045 XLEN=64, ld 0x8 -> be=0xFF; lwu 0xC with rdata[63:32]=0x90000000 -> lsu_data_o=0x0000000090000000.

Source files
------------

// File: rtl/miriscv_lsu_gnt_if.sv
// Data-memory bus between the load/store unit and memory.
// The LSU drives the request (data_req_o, data_we_o, data_be_o, data_addr_o,
// data_wdata_o); memory answers with data_gnt_i in the request cycle and with
// data_rvalid_i / data_rdata_i when a load response returns.
//   master : LSU side
//   slave  : memory side
interface miriscv_lsu_gnt_if #(
  parameter int XLEN = 32
);
  logic              data_req_o;
  logic              data_gnt_i;
  logic              data_rvalid_i;
  logic [XLEN-1:0]   data_rdata_i;
  logic              data_we_o;
  logic [XLEN/8-1:0] data_be_o;
  logic [XLEN-1:0]   data_addr_o;
  logic [XLEN-1:0]   data_wdata_o;

  modport master (
    output data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
    input  data_gnt_i, data_rvalid_i, data_rdata_i
  );

  modport slave (
    input  data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
    output data_gnt_i, data_rvalid_i, data_rdata_i
  );
endinterface

// File: rtl/miriscv_lsu_gnt.sv
// Load/store unit with a req/gnt + rvalid memory handshake.
// Issues one access at a time, stalls the pipeline while a request waits for
// grant or a load waits for its response, formats store lanes and load results,
// and flags misaligned/illegal accesses. A load squashed while outstanding is
// drained so its late response is never delivered.
// Ports:
//   clk_i, rst_n       clock, synchronous active-low reset
//   mem                data-memory bus (master modport)
//   lsu_req_i          pipeline access request
//   lsu_kill_i         squash the current access
//   lsu_we_i           1 = store, 0 = load
//   lsu_size_i         [1:0] byte/half/word/double, [2] unsigned load
//   lsu_addr_i         byte address
//   lsu_data_i         store data (right-aligned)
//   lsu_data_o         formatted load result (valid in the rvalid cycle)
//   lsu_stall_o        pipeline must hold the current request
//   lsu_misalign_o     misaligned or illegal access
module miriscv_lsu_gnt #(
  parameter int XLEN         = 32,
  parameter int MEM_ACCESS_W = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_n,
  miriscv_lsu_gnt_if.master       mem,
  input  logic                    lsu_req_i,
  input  logic                    lsu_kill_i,
  input  logic                    lsu_we_i,
  input  logic [MEM_ACCESS_W-1:0] lsu_size_i,
  input  logic [XLEN-1:0]         lsu_addr_i,
  input  logic [XLEN-1:0]         lsu_data_i,
  output logic [XLEN-1:0]         lsu_data_o,
  output logic                    lsu_stall_o,
  output logic                    lsu_misalign_o
);

  localparam int BE_W  = XLEN / 8;
  localparam int OFF_W = $clog2(BE_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_RVALID,
    S_DRAIN
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [OFF_W-1:0]        off_p1;
  logic [MEM_ACCESS_W-1:0] size_p1;
  logic                    misaligned;
  logic                    req_live;
  logic                    issue;
  logic                    load_grant;

  // Byte-enable pattern of an access before it is shifted into place.
  function automatic logic [BE_W-1:0] be_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    be_mask = BE_W'(1);
      2'd1:    be_mask = BE_W'(3);
      2'd2:    be_mask = BE_W'(15);
      default: be_mask = '1;
    endcase
  endfunction

  // Replicate the store operand into every lane so memory can pick any one.
  function automatic logic [XLEN-1:0] store_lanes(input logic [1:0]      sz,
                                                  input logic [XLEN-1:0] d);
    case (sz)
      2'd0:    store_lanes = {BE_W{d[7:0]}};
      2'd1:    store_lanes = {(XLEN/16){d[15:0]}};
      2'd2:    store_lanes = {(XLEN/32){d[31:0]}};
      default: store_lanes = d;
    endcase
  endfunction

  // Pull the addressed lane down to bit 0, then sign- or zero-extend.
  function automatic logic [XLEN-1:0] load_format(input logic [MEM_ACCESS_W-1:0] sz,
                                                  input logic [OFF_W-1:0]        off,
                                                  input logic [XLEN-1:0]         rd);
    logic        [XLEN-1:0] lane;
    logic signed [7:0]      lane_b;
    logic signed [15:0]     lane_h;
    logic signed [31:0]     lane_w;
    lane   = rd >> {off, 3'b000};
    lane_b = lane[7:0];
    lane_h = lane[15:0];
    lane_w = lane[31:0];
    case (sz[1:0])
      2'd0: begin
        if (sz[2]) load_format = XLEN'(lane[7:0]);
        else       load_format = XLEN'(lane_b);
      end
      2'd1: begin
        if (sz[2]) load_format = XLEN'(lane[15:0]);
        else       load_format = XLEN'(lane_h);
      end
      2'd2: begin
        if (sz[2]) load_format = XLEN'(lane[31:0]);
        else       load_format = XLEN'(lane_w);
      end
      default: load_format = lane;
    endcase
  endfunction

  // A double access does not exist on a 32-bit core, so it is reported
  // through the same misalignment path.
  always_comb begin
    case (lsu_size_i[1:0])
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = lsu_addr_i[0];
      2'd2:    misaligned = |lsu_addr_i[1:0];
      default: misaligned = (XLEN == 32) ? 1'b1 : |lsu_addr_i[2:0];
    endcase
  end

  assign req_live       = lsu_req_i & ~lsu_kill_i;
  assign lsu_misalign_o = req_live & misaligned;
  assign issue          = req_live & ~misaligned & (state == S_IDLE);

  assign mem.data_req_o   = issue;
  assign mem.data_we_o    = lsu_we_i;
  assign mem.data_addr_o  = lsu_addr_i;
  assign mem.data_be_o    = issue ? (be_mask(lsu_size_i[1:0]) << lsu_addr_i[OFF_W-1:0])
                                  : '0;
  assign mem.data_wdata_o = store_lanes(lsu_size_i[1:0], lsu_data_i);

  assign lsu_data_o = load_format(size_p1, off_p1, mem.data_rdata_i);

  always_comb begin
    state_next  = state;
    lsu_stall_o = 1'b0;
    load_grant  = 1'b0;
    case (state)
      S_IDLE: begin
        if (issue) begin
          if (!mem.data_gnt_i) begin
            lsu_stall_o = 1'b1;
          end else if (!lsu_we_i) begin
            // Stores retire on grant; loads wait for their response.
            lsu_stall_o = 1'b1;
            load_grant  = 1'b1;
            state_next  = S_WAIT_RVALID;
          end
        end
      end
      S_WAIT_RVALID: begin
        if (lsu_kill_i) begin
          state_next = mem.data_rvalid_i ? S_IDLE : S_DRAIN;
        end else if (mem.data_rvalid_i) begin
          state_next = S_IDLE;
        end else begin
          lsu_stall_o = 1'b1;
        end
      end
      S_DRAIN: begin
        // The squashed load's response is still owed; a new request must
        // wait until it has been swallowed.
        if (mem.data_rvalid_i) begin
          state_next = S_IDLE;
        end else begin
          lsu_stall_o = req_live;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Stage boundary: FSM state and the lane info of the outstanding load.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      off_p1  <= '0;
      size_p1 <= '0;
    end else begin
      state <= state_next;
      if (load_grant) begin
        off_p1  <= lsu_addr_i[OFF_W-1:0];
        size_p1 <= lsu_size_i;
      end
    end
  end

endmodule

// File: tb/tb_miriscv_lsu_gnt.sv
module tb_miriscv_lsu_gnt;

  typedef struct packed {
    logic        req;
    logic        kill;
    logic        we;
    logic [2:0]  size;
    logic [63:0] addr;
    logic [63:0] data;
    logic        gnt;
    logic        rvalid;
    logic [63:0] rdata;
  } in_t;

  typedef struct packed {
    logic        inst;
    logic        req;
    logic        stall;
    logic        mis;
    logic [7:0]  be;
    logic [63:0] wdata;
    logic [63:0] addr;
    logic        chk_data;
    logic [63:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req32, kill32, we32, stall32, mis32;
  logic [2:0]  size32;
  logic [31:0] addr32, din32, dout32;
  logic        req64, kill64, we64, stall64, mis64;
  logic [2:0]  size64;
  logic [63:0] addr64, din64, dout64;

  miriscv_lsu_gnt_if #(.XLEN(32)) m32 ();
  miriscv_lsu_gnt_if #(.XLEN(64)) m64 ();

  miriscv_lsu_gnt #(.XLEN(32), .MEM_ACCESS_W(3)) dut32 (
    .clk_i(clk), .rst_n(rst_n), .mem(m32.master),
    .lsu_req_i(req32), .lsu_kill_i(kill32), .lsu_we_i(we32), .lsu_size_i(size32),
    .lsu_addr_i(addr32), .lsu_data_i(din32), .lsu_data_o(dout32),
    .lsu_stall_o(stall32), .lsu_misalign_o(mis32)
  );

  miriscv_lsu_gnt #(.XLEN(64), .MEM_ACCESS_W(3)) dut64 (
    .clk_i(clk), .rst_n(rst_n), .mem(m64.master),
    .lsu_req_i(req64), .lsu_kill_i(kill64), .lsu_we_i(we64), .lsu_size_i(size64),
    .lsu_addr_i(addr64), .lsu_data_i(din64), .lsu_data_o(dout64),
    .lsu_stall_o(stall64), .lsu_misalign_o(mis64)
  );

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: per instance, whether a load is owed to the pipeline,
  // whether a squashed load's response is still owed, and the owed load's
  // byte offset / size.
  bit       owed[2];
  bit       discard[2];
  int       ld_off[2];
  bit [2:0] ld_size[2];

  function automatic exp_t model_eval(input int k, input in_t i);
    exp_t        e;
    int          xl;
    int          nbus;
    int          nb;
    int          off;
    int          lb;
    logic        active;
    logic [63:0] rd;
    logic [63:0] v;
    logic [63:0] m;
    e      = '0;
    xl     = (k != 0) ? 64 : 32;
    nbus   = xl / 8;
    nb     = 1 << i.size[1:0];
    off    = int'(i.addr[5:0]) % nbus;
    active = i.req && !i.kill;
    e.inst = (k != 0);
    e.mis  = active && ((nb == 8 && xl == 32) || (i.addr % nb) != 0);
    e.req  = active && !e.mis && !owed[k] && !discard[k];
    if (owed[k])         e.stall = !i.kill && !i.rvalid;
    else if (discard[k]) e.stall = active && !i.rvalid;
    else                 e.stall = e.req && !(i.gnt && i.we);
    e.be = e.req ? 8'((((1 << nb) - 1) << off) & ((1 << nbus) - 1)) : 8'd0;
    for (int b = 0; b < nbus; b++) e.wdata[8*b +: 8] = i.data[8*(b % nb) +: 8];
    e.addr = (xl == 32) ? {32'd0, i.addr[31:0]} : i.addr;
    rd = (xl == 32) ? {32'd0, i.rdata[31:0]} : i.rdata;
    e.chk_data = owed[k] && i.rvalid && !i.kill;
    lb = 1 << ld_size[k][1:0];
    v  = rd >> (8 * ld_off[k]);
    if (lb < 8) begin
      m = (64'd1 << (8 * lb)) - 64'd1;
      v = v & m;
      if (!ld_size[k][2] && v[8*lb-1]) v = v | ~m;
    end
    if (xl == 32) v = {32'd0, v[31:0]};
    e.data = v;
    return e;
  endfunction

  task automatic model_step(input int k, input in_t i, input logic r);
    exp_t e;
    e = model_eval(k, i);
    if (!r) begin
      owed[k] = 0; discard[k] = 0; ld_off[k] = 0; ld_size[k] = 0;
    end else if (owed[k]) begin
      if (i.kill) begin
        owed[k] = 0; discard[k] = !i.rvalid;
      end else if (i.rvalid) begin
        owed[k] = 0;
      end
    end else if (discard[k]) begin
      if (i.rvalid) discard[k] = 0;
    end else if (e.req && i.gnt && !i.we) begin
      owed[k]    = 1;
      ld_off[k]  = int'(i.addr[5:0]) % ((k != 0) ? 8 : 4);
      ld_size[k] = i.size;
    end
  endtask

  function automatic in_t mk(input logic req, input logic kill, input logic we,
                             input logic [2:0] sz, input logic [63:0] addr,
                             input logic [63:0] data, input logic gnt,
                             input logic rv, input logic [63:0] rd);
    in_t r;
    r.req = req; r.kill = kill; r.we = we; r.size = sz; r.addr = addr;
    r.data = data; r.gnt = gnt; r.rvalid = rv; r.rdata = rd;
    return r;
  endfunction

  function automatic in_t rnd(input int k);
    in_t r;
    int  nb;
    r.req    = ($urandom_range(0, 3) != 0);
    r.kill   = ($urandom_range(0, 9) == 0);
    r.we     = ($urandom_range(0, 2) == 0);
    r.size   = 3'($urandom_range(0, 7));
    if (k == 0 && r.size[1:0] == 2'd3 && $urandom_range(0, 1) == 0) r.size[1:0] = 2'd2;
    nb       = 1 << r.size[1:0];
    r.addr   = {$urandom(), $urandom()};
    if ($urandom_range(0, 3) != 0) r.addr = r.addr & ~64'(nb - 1);
    r.data   = {$urandom(), $urandom()};
    r.gnt    = ($urandom_range(0, 1) == 0);
    r.rvalid = ($urandom_range(0, 2) == 0);
    r.rdata  = {$urandom(), $urandom()};
    return r;
  endfunction

  task automatic drive(input in_t a, input in_t b);
    req32 = a.req; kill32 = a.kill; we32 = a.we; size32 = a.size;
    addr32 = a.addr[31:0]; din32 = a.data[31:0];
    m32.data_gnt_i = a.gnt; m32.data_rvalid_i = a.rvalid; m32.data_rdata_i = a.rdata[31:0];
    req64 = b.req; kill64 = b.kill; we64 = b.we; size64 = b.size;
    addr64 = b.addr; din64 = b.data;
    m64.data_gnt_i = b.gnt; m64.data_rvalid_i = b.rvalid; m64.data_rdata_i = b.rdata;
  endtask

  // One clock: apply inputs, record what both DUTs must show, advance the model.
  task automatic cycle(input in_t a, input in_t b, input logic r);
    rst_n = r;
    drive(a, b);
    sb.push_back(model_eval(0, a));
    sb.push_back(model_eval(1, b));
    @(posedge clk);
    model_step(0, a, r);
    model_step(1, b, r);
    #1;
  endtask

  task automatic chk(input string nm, input logic k, input logic [63:0] act,
                     input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s xlen%0d t=%0t got %h expected %h", nm, k ? 64 : 32, $time, act, exp_v);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (!e.inst) begin
        chk("req",      0, {63'd0, m32.data_req_o}, {63'd0, e.req});
        chk("stall",    0, {63'd0, stall32},        {63'd0, e.stall});
        chk("misalign", 0, {63'd0, mis32},          {63'd0, e.mis});
        chk("be",       0, {60'd0, m32.data_be_o},  {56'd0, e.be});
        chk("addr",     0, {32'd0, m32.data_addr_o}, e.addr);
        if (e.req) chk("wdata", 0, {32'd0, m32.data_wdata_o}, e.wdata);
        if (e.chk_data) chk("rdata", 0, {32'd0, dout32}, e.data);
      end else begin
        chk("req",      1, {63'd0, m64.data_req_o}, {63'd0, e.req});
        chk("stall",    1, {63'd0, stall64},        {63'd0, e.stall});
        chk("misalign", 1, {63'd0, mis64},          {63'd0, e.mis});
        chk("be",       1, {56'd0, m64.data_be_o},  {56'd0, e.be});
        chk("addr",     1, m64.data_addr_o,         e.addr);
        if (e.req) chk("wdata", 1, m64.data_wdata_o, e.wdata);
        if (e.chk_data) chk("rdata", 1, dout64, e.data);
      end
    end
  end

  initial begin : stim
    in_t idle;
    idle = '0;
    foreach (owed[k]) begin
      owed[k] = 0; discard[k] = 0; ld_off[k] = 0; ld_size[k] = 0;
    end
    rst_n = 1'b0;
    drive(idle, idle);
    @(posedge clk);
    #1;
    cycle(idle, idle, 1'b0);
    cycle(idle, idle, 1'b0);
    cycle(idle, idle, 1'b1);

    // lw 0x100, grant at once, response three cycles later
    cycle(mk(1, 0, 0, 3'd2, 64'h100, 0, 1, 0, 0), idle, 1'b1);
    cycle(mk(1, 0, 0, 3'd2, 64'h100, 0, 0, 0, 0), idle, 1'b1);
    cycle(mk(1, 0, 0, 3'd2, 64'h100, 0, 0, 0, 0), idle, 1'b1);
    cycle(mk(1, 0, 0, 3'd2, 64'h100, 0, 0, 1, 64'hDEADBEEF), idle, 1'b1);
    // lb / lbu 0x103
    cycle(mk(1, 0, 0, 3'd0, 64'h103, 0, 1, 0, 0), idle, 1'b1);
    cycle(mk(1, 0, 0, 3'd0, 64'h103, 0, 0, 1, 64'h80123456), idle, 1'b1);
    cycle(mk(1, 0, 0, 3'd4, 64'h103, 0, 1, 0, 0), idle, 1'b1);
    cycle(mk(1, 0, 0, 3'd4, 64'h103, 0, 0, 1, 64'h80123456), idle, 1'b1);
    // sh 0x102, grant two cycles late
    cycle(mk(1, 0, 1, 3'd1, 64'h102, 64'h1234, 0, 0, 0), idle, 1'b1);
    cycle(mk(1, 0, 1, 3'd1, 64'h102, 64'h1234, 0, 0, 0), idle, 1'b1);
    cycle(mk(1, 0, 1, 3'd1, 64'h102, 64'h1234, 1, 0, 0), idle, 1'b1);
    // misaligned word, illegal double on 32-bit
    cycle(mk(1, 0, 0, 3'd2, 64'h101, 0, 1, 0, 0), idle, 1'b1);
    cycle(mk(1, 0, 0, 3'd3, 64'h0, 0, 1, 0, 0), idle, 1'b1);
    // load killed while outstanding, new lw waits for the drain
    cycle(mk(1, 0, 0, 3'd2, 64'h100, 0, 1, 0, 0), idle, 1'b1);
    cycle(mk(1, 1, 0, 3'd2, 64'h100, 0, 0, 0, 0), idle, 1'b1);
    cycle(mk(1, 0, 0, 3'd2, 64'h200, 0, 1, 0, 0), idle, 1'b1);
    cycle(mk(1, 0, 0, 3'd2, 64'h200, 0, 1, 1, 64'h5555AAAA), idle, 1'b1);
    cycle(mk(1, 0, 0, 3'd2, 64'h200, 0, 1, 0, 0), idle, 1'b1);
    cycle(mk(1, 0, 0, 3'd2, 64'h200, 0, 0, 1, 64'h12345678), idle, 1'b1);
    // 64-bit: ld 0x8, lwu 0xC
    cycle(idle, mk(1, 0, 0, 3'd3, 64'h8, 0, 1, 0, 0), 1'b1);
    cycle(idle, mk(1, 0, 0, 3'd3, 64'h8, 0, 0, 1, 64'h0123456789ABCDEF), 1'b1);
    cycle(idle, mk(1, 0, 0, 3'd6, 64'hC, 0, 1, 0, 0), 1'b1);
    cycle(idle, mk(1, 0, 0, 3'd6, 64'hC, 0, 0, 1, 64'h90000000_11223344), 1'b1);

    for (int n = 0; n < 4000; n++) begin
      cycle(rnd(0), rnd(1), ($urandom_range(0, 99) != 0));
    end

    @(negedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
